mem_seq_ctrl: RTL and testbench



---
 rtl/mem_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mem_seq_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: sequencer for the byte-wide data memory feeding the systolic array.
// Loads a block from an upstream valid/ready byte stream into memory, streams a
// block back out one byte per cycle (covering the memory's 1-cycle registered read
// latency) and rejects empty or out-of-range transfers with an err pulse.
//
// Optional feature: define MEM_SEQ_CTRL_CLEAR_EN to enable the CLEAR operation
// (zero-fill of the whole memory). Without it clear_start is ignored.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   load_start/base/len          load request (sampled in IDLE)
//   in_valid, in_data, in_ready  upstream byte stream
//   stream_start/base/len        stream request (sampled in IDLE)
//   clear_start                  memory clear request
//   out_valid/out_data/out_last  byte stream toward the array
//   busy, done, err              status; done/err are one-cycle pulses
//   mem_*                        exclusive write/read ports of the data memory
module mem_seq_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              stream_start,
  input  logic [ADDR_W-1:0] stream_base,
  input  logic [ADDR_W-1:0] stream_len,
  input  logic              clear_start,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_wr_enable,
  output logic [ADDR_W-1:0] mem_write_select,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [ADDR_W-1:0] mem_read_select,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
`ifdef MEM_SEQ_CTRL_CLEAR_EN
  localparam logic [2:0] StClear  = 3'd4;
`endif

  localparam logic [ADDR_W:0]   DepthW    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] DepthLast = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] One       = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  // Range check at ADDR_W+1 bits so base+len cannot wrap into a legal value.
  logic [ADDR_W:0]   load_end, stream_end;
  logic              load_ok, stream_ok;
  logic [ADDR_W-1:0] addr;
  logic              last_cnt;

  assign load_end   = {1'b0, load_base} + {1'b0, load_len};
  assign stream_end = {1'b0, stream_base} + {1'b0, stream_len};
  assign load_ok    = (load_len != '0) && (load_end <= DepthW);
  assign stream_ok  = (stream_len != '0) && (stream_end <= DepthW);
  assign addr       = base_q + cnt_q;
  assign last_cnt   = (cnt_q == (len_q - One));

`ifndef MEM_SEQ_CTRL_CLEAR_EN
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef MEM_SEQ_CTRL_CLEAR_EN
        if (clear_start) begin
          state_d = StClear;
        end else
`endif
        if (load_start) begin
          if (load_ok) begin
            state_d = StLoad;
            base_d  = load_base;
            len_d   = load_len;
          end else begin
            err_d = 1'b1;
          end
        end else if (stream_start) begin
          if (stream_ok) begin
            state_d = StStream;
            base_d  = stream_base;
            len_d   = stream_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          cnt_d = cnt_q + One;
          if (last_cnt) begin
            state_d = StIdle;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      StStream: begin
        // Read issued this cycle returns next cycle, hence registered valid/last.
        out_valid_d = 1'b1;
        out_last_d  = last_cnt;
        cnt_d       = cnt_q + One;
        if (last_cnt) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
`ifdef MEM_SEQ_CTRL_CLEAR_EN
      StClear: begin
        cnt_d = cnt_q + One;
        if (cnt_q == DepthLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Memory ports are decoded straight from state so reset drops them at once.
  always_comb begin
    in_ready         = (state_q == StLoad);
    mem_wr_enable    = 1'b0;
    mem_write_select = '0;
    mem_write_data   = '0;
    mem_read_select  = '0;
    if (state_q == StLoad) begin
      mem_wr_enable    = in_valid;
      mem_write_select = addr;
      mem_write_data   = in_data;
    end
`ifdef MEM_SEQ_CTRL_CLEAR_EN
    if (state_q == StClear) begin
      mem_wr_enable    = 1'b1;
      mem_write_select = cnt_q;
    end
`endif
    if (state_q == StStream) begin
      mem_read_select = addr;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = mem_read_data;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: table-driven operations, hand-written
// corner sequences and randomized operations against a reference memory image.
module tb_mem_seq_ctrl;

  localparam int DEPTH = 2500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [13:0] load_base = '0;
  logic [13:0] load_len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        stream_start = 1'b0;
  logic [13:0] stream_base = '0;
  logic [13:0] stream_len = '0;
  logic        clear_start = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_wr_enable;
  logic [13:0] mem_write_select;
  logic [7:0]  mem_write_data;
  logic [13:0] mem_read_select;
  logic [7:0]  mem_read_data = '0;

  always #5 clk = ~clk;

  mem_seq_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .load_start       (load_start),
    .load_base        (load_base),
    .load_len         (load_len),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .stream_start     (stream_start),
    .stream_base      (stream_base),
    .stream_len       (stream_len),
    .clear_start      (clear_start),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .mem_wr_enable    (mem_wr_enable),
    .mem_write_select (mem_write_select),
    .mem_write_data   (mem_write_data),
    .mem_read_select  (mem_read_select),
    .mem_read_data    (mem_read_data)
  );

  // Physical memory (written by the DUT) and the bench's expected image.
  logic [7:0]  mem [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  logic [13:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [7:0]  od_q[$];
  logic        ol_q[$];

  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_enable === 1'b1) begin
        wa_q.push_back(mem_write_select);
        wd_q.push_back(mem_write_data);
        if (int'(mem_write_select) < DEPTH) mem[mem_write_select] = mem_write_data;
      end
      if (out_valid === 1'b1) begin
        od_q.push_back(out_data);
        ol_q.push_back(out_last);
      end
    end
  end

  always @(posedge clk) begin
    mem_read_data <= (int'(mem_read_select) < DEPTH) ? mem[mem_read_select] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    od_q.delete();
    ol_q.delete();
  endtask

  // Runs one load or stream request and checks it end to end.
  task automatic run_op(input bit is_load, input int base, input int len, input bit gaps,
                        input logic [7:0] dat0, input bit exp_err, input string tag);
    int bad;
    int k;
    int cyc;
    logic v;
    logic [7:0] exp_d[$];
    clear_logs();
    if (is_load) begin
      load_start = 1'b1; load_base = 14'(base); load_len = 14'(len);
    end else begin
      stream_start = 1'b1; stream_base = 14'(base); stream_len = 14'(len);
    end
    step();
    load_start = 1'b0;
    stream_start = 1'b0;
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy0"}, busy, !exp_err);
    if (exp_err) begin
      step();
      chk({tag, "_err_pulse"}, err, 0);
      step();
      chk({tag, "_rej_busy"}, busy, 0);
      chk({tag, "_rej_writes"}, wa_q.size(), 0);
      chk({tag, "_rej_outs"}, od_q.size(), 0);
      return;
    end
    bad = 0;
    if (is_load) begin
      k = 0;
      cyc = 0;
      while (k < len && cyc < 4 * len + 10) begin
        if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
        v = gaps ? (cyc % 2 == 0) : 1'b1;
        in_valid = v;
        in_data = (dat0 != 0) ? dat0 + 8'(k) : 8'($urandom);
        if (v) begin
          ref_mem[base + k] = in_data;
          exp_d.push_back(in_data);
          k++;
        end
        step();
        cyc++;
      end
      in_valid = 1'b0;
      chk({tag, "_accepts"}, k, len);
      chk({tag, "_load_status"}, bad, 0);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_ready"}, in_ready, 0);
      step();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_nwrites"}, wa_q.size(), len);
      bad = 0;
      for (int i = 0; i < wa_q.size() && i < len; i++) begin
        if (int'(wa_q[i]) != base + i || wd_q[i] !== exp_d[i]) bad++;
      end
      chk({tag, "_writes"}, bad, 0);
    end else begin
      for (int c = 1; c <= len + 2; c++) begin
        if (out_valid !== (c >= 2 && c <= len + 1)) bad++;
        if (out_last !== (c == len + 1)) bad++;
        if (done !== (c == len + 2)) bad++;
        if (busy !== (c <= len + 1)) bad++;
        if (in_ready !== 1'b0 || mem_wr_enable !== 1'b0) bad++;
        if (c <= len && int'(mem_read_select) != base + c - 1) bad++;
        if (c < len + 2) step();
      end
      chk({tag, "_stream_timing"}, bad, 0);
      step();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_nbytes"}, od_q.size(), len);
      bad = 0;
      for (int i = 0; i < od_q.size() && i < len; i++) begin
        if (od_q[i] !== ref_mem[base + i] || ol_q[i] !== (i == len - 1)) bad++;
      end
      chk({tag, "_bytes"}, bad, 0);
    end
  endtask

  typedef struct {
    bit         is_load;
    int         base;
    int         len;
    bit         gaps;
    logic [7:0] dat0;
    bit         exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int bad;
    int cyc;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end

    vecs[0]  = '{1, 10, 4, 0, 8'hA1, 0};
    vecs[1]  = '{0, 10, 4, 0, 8'h00, 0};
    vecs[2]  = '{1, 20, 3, 1, 8'h00, 0};
    vecs[3]  = '{0, 20, 3, 0, 8'h00, 0};
    vecs[4]  = '{1, 2498, 3, 0, 8'h00, 1};
    vecs[5]  = '{0, 0, 0, 0, 8'h00, 1};
    vecs[6]  = '{1, 2497, 3, 0, 8'h00, 0};
    vecs[7]  = '{0, 2497, 3, 0, 8'h00, 0};
    vecs[8]  = '{0, 2499, 1, 0, 8'h00, 0};
    vecs[9]  = '{1, 0, 1, 0, 8'h00, 0};
    vecs[10] = '{0, 2500, 1, 0, 8'h00, 1};
    vecs[11] = '{0, 16383, 1, 0, 8'h00, 1};
    vecs[12] = '{1, 5, 0, 1, 8'h00, 1};

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", mem_wr_enable, 0);
    repeat (3) step();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].is_load, vecs[i].base, vecs[i].len, vecs[i].gaps, vecs[i].dat0,
             vecs[i].exp_err, $sformatf("vec%0d", i));
      step();
    end

    // Load and stream requested together: load wins, stream dropped silently.
    clear_logs();
    load_start = 1'b1; load_base = 14'd30; load_len = 14'd2;
    stream_start = 1'b1; stream_base = 14'd0; stream_len = 14'd5;
    step();
    load_start = 1'b0; stream_start = 1'b0;
    chk("prio_ready", in_ready, 1);
    chk("prio_err", err, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 8'h70 + 8'(k);
      ref_mem[30 + k] = in_data;
      step();
    end
    in_valid = 1'b0;
    chk("prio_done", done, 1);
    repeat (4) step();
    chk("prio_writes", wa_q.size(), 2);
    chk("prio_no_stream", od_q.size(), 0);
    chk("prio_err_after", err, 0);

    // Reset in the middle of a stream.
    clear_logs();
    stream_start = 1'b1; stream_base = 14'd0; stream_len = 14'd10;
    step();
    stream_start = 1'b0;
    repeat (3) step();
    chk("midrst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    step();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    chk("midrst_idle", bad, 0);

    // Reset in the middle of a load drops the write enable at once.
    load_start = 1'b1; load_base = 14'd100; load_len = 14'd5;
    step();
    load_start = 1'b0;
    in_valid = 1'b1; in_data = 8'hEE;
    #1;
    chk("ldrst_pre_wr", mem_wr_enable, 1);
    rst = 1'b1;
    #1;
    chk("ldrst_wr", mem_wr_enable, 0);
    chk("ldrst_ready", in_ready, 0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_op(0, 10, 4, 0, 8'h00, 0, "post_rst_stream");
    step();

    // Clear.
    clear_logs();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
`ifdef MEM_SEQ_CTRL_CLEAR_EN
    bad = 0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 2600) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      step();
      cyc++;
    end
    chk("clr_status", bad, 0);
    chk("clr_done_cycle", cyc, DEPTH + 1);
    chk("clr_nwrites", wa_q.size(), DEPTH);
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) if (int'(wa_q[i]) != i || wd_q[i] !== 8'h00) bad++;
    chk("clr_writes", bad, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    step();
    run_op(0, 0, DEPTH, 0, 8'h00, 0, "clr_stream");
`else
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) bad++;
      step();
    end
    chk("clr_ignored", bad, 0);
    chk("clr_no_writes", wa_q.size(), 0);
`endif
    step();

    // Randomized operations against the reference image.
    for (int n = 0; n < 30; n++) begin
      bit is_load;
      int base;
      int len;
      is_load = 1'($urandom % 2);
      base = $urandom_range(0, 2520);
      len = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 24);
      run_op(is_load, base, len, 1'($urandom % 2), 8'h00, (len == 0) || (base + len > DEPTH),
             $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
